// File: rtl/keypad_entry_if.sv
// Entry-result bus of the keypad scanner: the confirm strobe, the confirmed
// value and the live entry state shown on the display.
interface keypad_entry_if;
    logic       flag;
    logic [9:0] key_num;
    logic [9:0] entry_val;
    logic       entry_active;

    modport master (output flag, key_num, entry_val, entry_active);
    modport slave  (input  flag, key_num, entry_val, entry_active);
endinterface

// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with debounce and decimal number entry.
// Digits build a value up to MAX_VAL; A confirms it (one-cycle flag),
// B deletes the last digit, C clears the entry. *, # and D are debounced
// but do nothing.
// Optional feature: define KEYPAD_BEEP_EN to add a `beep` output that pulses
// for BEEP_CYCLES clocks on every accepted key action.
module keypad_entry #(
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned DEB_TICKS   = 4,
    parameter int unsigned MAX_VAL     = 999
`ifdef KEYPAD_BEEP_EN
    ,
    parameter int unsigned BEEP_CYCLES = 5000000
`endif
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [3:0]     row_in,
    output logic [3:0]     col_out,
    keypad_entry_if.master bus
`ifdef KEYPAD_BEEP_EN
    ,
    output logic           beep
`endif
);

    localparam int unsigned DIVW = $clog2(SCAN_DIV);
    localparam int unsigned DW   = $clog2(DEB_TICKS + 1);

    typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

    state_t          state_q, state_d;
    logic [DIVW-1:0] div_q;
    logic            tick;
    logic [1:0]      col_q, col_d;
    logic [DW-1:0]   deb_q, deb_d, deb_inc;
    logic [3:0]      code_q, code_d;
    logic [3:0]      pat_q, pat_d;
    logic            armed_q, armed_d;
    logic [1:0]      idle_q, idle_d;
    logic            act;

    logic [3:0]      rows_low;
    logic            one_low;
    logic [1:0]      row_idx;

    logic [9:0]      entry_val_q, key_num_q;
    logic            entry_active_q, flag_q;
    logic [2:0]      dcnt_q;

    logic            is_digit, is_enter, is_bksp, is_clear;
    logic [3:0]      digit;
    logic [13:0]     prod;
    logic [9:0]      bs_val;
    logic            digit_fits;

    assign tick     = (div_q == DIVW'(SCAN_DIV - 1));
    assign rows_low = ~row_in;
    assign one_low  = (rows_low != 4'd0) && ((rows_low & (rows_low - 4'd1)) == 4'd0);
    assign deb_inc  = deb_q + DW'(1);
    assign col_out  = ~(4'b0001 << col_q);

    // Free-running scan tick divider
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  div_q <= '0;
        else if (tick) div_q <= '0;
        else           div_q <= div_q + DIVW'(1);
    end

    // Index of the single low row
    always_comb begin
        row_idx = 2'd0;
        case (rows_low)
            4'b0010: row_idx = 2'd1;
            4'b0100: row_idx = 2'd2;
            4'b1000: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
    end

    // Scanner / debounce state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SCAN;
            col_q   <= '0;
            deb_q   <= '0;
            code_q  <= '0;
            pat_q   <= '1;
            armed_q <= 1'b0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            deb_q   <= deb_d;
            code_q  <= code_d;
            pat_q   <= pat_d;
            armed_q <= armed_d;
            idle_q  <= idle_d;
        end
    end

    // Scanner next-state; after reset a full empty sweep is required before
    // any key is accepted, so a key held across reset must be released first
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        deb_d   = deb_q;
        code_d  = code_q;
        pat_d   = pat_q;
        armed_d = armed_q;
        idle_d  = idle_q;
        act     = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (!armed_q) begin
                        if (rows_low == 4'd0) begin
                            if (idle_q == 2'd3) armed_d = 1'b1;
                            else                idle_d  = idle_q + 2'd1;
                        end else begin
                            idle_d = '0;
                        end
                        col_d = col_q + 2'd1;
                    end else if (one_low) begin
                        code_d = {row_idx, col_q};
                        pat_d  = row_in;
                        deb_d  = DW'(1);
                        if (DEB_TICKS <= 1) begin
                            act     = 1'b1;
                            state_d = HELD;
                        end else begin
                            state_d = DEB_PRESS;
                        end
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                DEB_PRESS: begin
                    if (row_in == pat_q) begin
                        deb_d = deb_inc;
                        if (deb_inc == DW'(DEB_TICKS)) begin
                            act     = 1'b1;
                            state_d = HELD;
                        end
                    end else begin
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (&row_in) begin
                        deb_d = DW'(1);
                        if (DEB_TICKS <= 1) begin
                            col_d   = col_q + 2'd1;
                            state_d = SCAN;
                        end else begin
                            state_d = DEB_REL;
                        end
                    end
                end
                DEB_REL: begin
                    if (&row_in) begin
                        deb_d = deb_inc;
                        if (deb_inc == DW'(DEB_TICKS)) begin
                            col_d   = col_q + 2'd1;
                            state_d = SCAN;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    // Key decode of the code being acted on
    always_comb begin
        is_digit = 1'b1;
        is_enter = 1'b0;
        is_bksp  = 1'b0;
        is_clear = 1'b0;
        digit    = 4'd0;
        case (code_d)
            4'd0:    digit = 4'd1;
            4'd1:    digit = 4'd2;
            4'd2:    digit = 4'd3;
            4'd4:    digit = 4'd4;
            4'd5:    digit = 4'd5;
            4'd6:    digit = 4'd6;
            4'd8:    digit = 4'd7;
            4'd9:    digit = 4'd8;
            4'd10:   digit = 4'd9;
            4'd13:   digit = 4'd0;
            4'd3:    begin is_digit = 1'b0; is_enter = 1'b1; end
            4'd7:    begin is_digit = 1'b0; is_bksp  = 1'b1; end
            4'd11:   begin is_digit = 1'b0; is_clear = 1'b1; end
            default: is_digit = 1'b0;
        endcase
    end

    assign prod       = {4'b0, entry_val_q} * 14'd10 + {10'b0, digit};
    assign digit_fits = (prod <= 14'(MAX_VAL));
    assign bs_val     = entry_val_q / 10'd10;

    // Entry datapath: one action per accepted press
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entry_val_q    <= '0;
            entry_active_q <= 1'b0;
            key_num_q      <= '0;
            flag_q         <= 1'b0;
            dcnt_q         <= '0;
        end else begin
            flag_q <= 1'b0;
            if (act) begin
                if (is_digit) begin
                    if (digit_fits) begin
                        entry_val_q    <= prod[9:0];
                        entry_active_q <= 1'b1;
                        if (dcnt_q != 3'd4) dcnt_q <= dcnt_q + 3'd1;
                    end
                end else if (is_enter) begin
                    if (entry_active_q) begin
                        key_num_q      <= entry_val_q;
                        flag_q         <= 1'b1;
                        entry_val_q    <= '0;
                        entry_active_q <= 1'b0;
                        dcnt_q         <= '0;
                    end
                end else if (is_bksp) begin
                    entry_val_q <= bs_val;
                    if (dcnt_q != 3'd0) dcnt_q <= dcnt_q - 3'd1;
                    if (bs_val == 10'd0 && dcnt_q <= 3'd1) entry_active_q <= 1'b0;
                end else if (is_clear) begin
                    entry_val_q    <= '0;
                    entry_active_q <= 1'b0;
                    dcnt_q         <= '0;
                end
            end
        end
    end

    assign bus.flag         = flag_q;
    assign bus.key_num      = key_num_q;
    assign bus.entry_val    = entry_val_q;
    assign bus.entry_active = entry_active_q;

`ifdef KEYPAD_BEEP_EN
    localparam int unsigned BW = $clog2(BEEP_CYCLES + 1);

    logic [BW-1:0] beep_q;
    logic          beep_start;

    assign beep_start = act && (is_enter || is_bksp || is_clear || (is_digit && digit_fits));

    // Beep duration counter, restarted by every accepted action
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              beep_q <= '0;
        else if (beep_start)       beep_q <= BW'(BEEP_CYCLES);
        else if (beep_q != '0)     beep_q <= beep_q - BW'(1);
    end

    assign beep = (beep_q != '0);
`endif

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: a behavioural keypad matrix model,
// a vector table of key presses, and hand-written multi-cycle sequences.
module tb_keypad_entry;

    localparam int SD = 4;
    localparam int DT = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] mask = '0;
`ifdef KEYPAD_BEEP_EN
    logic        beep;
`endif

    keypad_entry_if bus();

    keypad_entry #(
        .SCAN_DIV(SD),
        .DEB_TICKS(DT),
        .MAX_VAL(999)
`ifdef KEYPAD_BEEP_EN
        ,
        .BEEP_CYCLES(20)
`endif
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .row_in(row_in),
        .col_out(col_out),
        .bus(bus)
`ifdef KEYPAD_BEEP_EN
        ,
        .beep(beep)
`endif
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven
    always_comb begin
        row_in = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (mask[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    int         flag_cyc = 0;
    int         flag_b2b = 0;
    int         val_changes = 0;
    int         beep_cyc = 0;
    logic       prev_flag = 1'b0;
    logic [9:0] prev_val = '0;

    // Output monitors, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.flag) flag_cyc++;
        if (bus.flag && prev_flag) flag_b2b++;
        if (bus.entry_val != prev_val) val_changes++;
        prev_flag = bus.flag;
        prev_val  = bus.entry_val;
`ifdef KEYPAD_BEEP_EN
        if (beep) beep_cyc++;
`endif
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
        else passed++;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * SD) @(posedge clk);
    endtask

    task automatic press(input logic [15:0] m);
        mask = m;
        wait_ticks(12);
        mask = '0;
        wait_ticks(8);
    endtask

    typedef struct {
        logic [15:0] m;
        logic [9:0]  val;
        logic        active;
        int          flags;
        logic [9:0]  knum;
    } vec_t;

    vec_t v[15];

    initial begin
        int f0, c0, b0;

        // mask bit = row*4+col of the key
        v[0]  = '{16'h0001,   1, 1'b1, 0, 125}; // 1
        v[1]  = '{16'h0002,  12, 1'b1, 0, 125}; // 2
        v[2]  = '{16'h0020, 125, 1'b1, 0, 125}; // 5
        v[3]  = '{16'h0008,   0, 1'b0, 1, 125}; // A
        v[4]  = '{16'h0400,   9, 1'b1, 0, 125}; // 9
        v[5]  = '{16'h0400,  99, 1'b1, 0, 125}; // 9
        v[6]  = '{16'h0400, 999, 1'b1, 0, 125}; // 9
        v[7]  = '{16'h0400, 999, 1'b1, 0, 125}; // 9, over MAX_VAL
        v[8]  = '{16'h0080,  99, 1'b1, 0, 125}; // B
        v[9]  = '{16'h0800,   0, 1'b0, 0, 125}; // C
        v[10] = '{16'h0008,   0, 1'b0, 0, 125}; // A with nothing typed
        v[11] = '{16'h1000,   0, 1'b0, 0, 125}; // * ignored
        v[12] = '{16'h0022,   0, 1'b0, 0, 125}; // 2+5 together, same column
        v[13] = '{16'h2000,   0, 1'b1, 0, 125}; // 0
        v[14] = '{16'h0008,   0, 1'b0, 1,   0}; // A confirms 0

        // The first-row results only hold if the 125 entry is confirmed first
        v[0].knum = 0; v[1].knum = 0; v[2].knum = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_col_out", col_out, 4'b1110);
        check("rst_flag", bus.flag, 0);
        check("rst_key_num", bus.key_num, 0);
        check("rst_entry_val", bus.entry_val, 0);
        check("rst_entry_active", bus.entry_active, 0);
        reset_n = 1'b1;
        wait_ticks(10);

        for (int i = 0; i < 15; i++) begin
            f0 = flag_cyc;
            press(v[i].m);
            @(negedge clk);
            check($sformatf("v%0d_entry_val", i), bus.entry_val, v[i].val);
            check($sformatf("v%0d_entry_active", i), bus.entry_active, v[i].active);
            check($sformatf("v%0d_flag_cycles", i), flag_cyc - f0, v[i].flags);
            check($sformatf("v%0d_key_num", i), bus.key_num, v[i].knum);
        end

        // Bounce on key 7, then a stable press
        c0 = val_changes;
        for (int i = 0; i < 5; i++) begin
            mask = 16'h0100;
            wait_ticks(1);
            mask = '0;
            wait_ticks(1);
        end
        @(negedge clk);
        check("bounce_no_action", val_changes - c0, 0);
        mask = 16'h0100;
        wait_ticks(12);
        mask = '0;
        wait_ticks(8);
        @(negedge clk);
        check("bounce_entry_val", bus.entry_val, 7);
        check("bounce_single_action", val_changes - c0, 1);

        press(16'h0800);
        @(negedge clk);
        check("clear_entry_val", bus.entry_val, 0);

        // Long hold of key 3, then reset while still held
        c0 = val_changes;
        mask = 16'h0004;
        wait_ticks(100);
        @(negedge clk);
        check("hold_entry_val", bus.entry_val, 3);
        check("hold_single_action", val_changes - c0, 1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_col_out", col_out, 4'b1110);
        check("midrst_flag", bus.flag, 0);
        check("midrst_key_num", bus.key_num, 0);
        check("midrst_entry_val", bus.entry_val, 0);
        check("midrst_entry_active", bus.entry_active, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_ticks(20);
        @(negedge clk);
        check("held_across_reset", bus.entry_val, 0);
        mask = '0;
        wait_ticks(10);
        press(16'h0010);
        @(negedge clk);
        check("after_rst_entry_val", bus.entry_val, 4);
        check("after_rst_entry_active", bus.entry_active, 1);

`ifdef KEYPAD_BEEP_EN
        b0 = beep_cyc;
        press(16'h0200);
        @(negedge clk);
        check("beep_digit_cycles", beep_cyc - b0, 20);
        check("beep_digit_val", bus.entry_val, 48);
        b0 = beep_cyc;
        press(16'h8000);
        @(negedge clk);
        check("beep_ignored_key", beep_cyc - b0, 0);
`else
        b0 = 0;
`endif

        check("flag_back_to_back", flag_b2b, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- 4x4 matrix keypad scanner with debounce and decimal number entry for the taxi meter.
- Converts operator key presses into a 10-bit value plus a one-cycle `flag` strobe. This is the `flag`/`key_num` interface consumed by the fare-setting logic (start fee / unit price).
- Sits between the board keypad pins and the price-setting block.

Parameters:
- SCAN_DIV, 50000, clk cycles per scan tick (min 2).
- DEB_TICKS, 4, consecutive stable ticks needed to accept a press or a release (min 1).
- MAX_VAL, 999, largest value an entry may reach (must be ≤1023).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- row_in  in  4  keypad rows, active-low, external pull-ups
- col_out  out  4  keypad column drive, one-hot active-low
- flag  out  1  one-cycle strobe, entry confirmed
- key_num  out  10  confirmed value; valid when flag=1, held afterwards
- entry_val  out  10  value currently being typed, for display
- entry_active  out  1  at least one digit typed since last confirm/clear

Behaviour:
- Reset (reset_n=0, async):
  - col_out=4'b1110 (column 0), flag=0, key_num=0, entry_val=0, entry_active=0.
  - FSM=SCAN; all counters 0.
- Scan tick: 1-clk internal pulse every SCAN_DIV clks, free-running.
- Key code = row*4+col. Layout (row 0 first): 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
  - Digits: 0-9.
  - A = ENTER, B = BACKSPACE, C = CLEAR.
  - *, #, D are ignored: no state change, but still debounced.
- FSM states SCAN, DEB_PRESS, HELD, DEB_REL:
  - SCAN:
    - On each tick, sample row_in for the driven column.
    - If exactly one row is low: latch the code, go DEB_PRESS, deb_cnt=1, hold the column.
    - Otherwise advance the column (3→0 wrap).
    - Two or more rows low in one column: treated as no key.
  - DEB_PRESS:
    - On each tick, if the same single row is still low, deb_cnt++; otherwise return to SCAN without acting.
    - When deb_cnt reaches DEB_TICKS: execute the key action in that clk and go HELD.
  - HELD: on each tick, if all rows are high go DEB_REL with deb_cnt=1.
  - DEB_REL:
    - On each tick, all rows high → deb_cnt++; any row low → back to HELD.
    - At DEB_TICKS: advance the column and go SCAN.
  - A key held down acts once only; there is no auto-repeat.
- Key actions (1 per accepted press):
  - Digit d:
    - If entry_val*10+d ≤ MAX_VAL: entry_val <= entry_val*10+d, entry_active <= 1.
    - Otherwise the digit is ignored and entry_val is unchanged.
    - Multiply in ≥14-bit arithmetic before the compare.
  - ENTER:
    - If entry_active: key_num <= entry_val, flag=1 for exactly that clk, then entry_val <= 0, entry_active <= 0.
    - If !entry_active: no flag; key_num is unchanged.
  - BACKSPACE:
    - entry_val <= entry_val/10.
    - entry_active <= 0 if the result is 0 and it was a single-digit entry; track the digit count (0..4) to decide this.
  - CLEAR: entry_val <= 0, entry_active <= 0, no flag.
- Latency: the action (and flag) occurs in the clk of the DEB_TICKS-th consecutive stable tick, i.e. (DEB_TICKS)×SCAN_DIV clks after first detection, ±1 tick.
- Leading zeros: accepted; entry_active becomes 1 and entry_val stays 0. ENTER then confirms 0.
- Reset mid-entry or mid-debounce: everything returns to reset values; the key being pressed must be released and re-debounced before it acts.
- flag never asserts two cycles in a row.

Optional Feature:
- Macro: KEYPAD_BEEP_EN.
- When defined:
  - Adds output port `beep` (out, 1) and parameter BEEP_CYCLES (default 5000000).
  - beep=1 for BEEP_CYCLES clks, starting in the action clk of every accepted digit/ENTER/BACKSPACE/CLEAR.
  - A new action restarts the count.
  - Ignored keys and overflow-rejected digits do not beep.
  - beep resets to 0.
- When undefined: no `beep` port, no counter logic; all other behaviour identical.

Test Plan:
- SCAN_DIV=4, DEB_TICKS=3; press 1, 2, 5, A with full release between keys → flag high exactly 1 clk, key_num=125; then entry_val=0, entry_active=0.
- Bounce: row toggles low/high every tick ×5, then stable low for 3 ticks on key 7 → exactly one action, entry_val=7; no action during the bounce.
- Overflow: type 9, 9, 9, 9 → entry_val=999, 4th digit ignored. Then B → 99; C → 0. Then A → no flag, key_num still 125.
- Two rows low in column 1 (keys 2 and 5) → no action, scan continues; then release and press 0, A → flag, key_num=0.
- Hold key 3 for 100 ticks → entry_val=3 only (single action). Assert reset_n=0 mid-hold → all outputs return to reset values; after release, press 4 → entry_val=4.
- With KEYPAD_BEEP_EN, BEEP_CYCLES=20: press 8 → beep high 20 clks from the action clk; press D → no beep.
